instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache that responds to the fetch stage's PC and returns the instruction word plus a valid flag.
- Hits answer in the same cycle as the address, so fetch latches the word on the next clk edge.
- On a miss it raises a stall to fetch and refills the whole line from the memory bus with a req/ready beat handshake.
- Sits between the fetch stage and the instruction memory/bus interface.

Parameters:
DATA_WIDTH, 32, width of address, instruction and memory data.
LINES, 16, number of cache lines; power of two, >= 2.
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
fetch_address  input  DATA_WIDTH  PC from the fetch stage; bits [1:0] are ignored.
invalidate  input  1  one-cycle pulse; clears all line valid bits (fence.i / self-modifying code).
cache_out  output  DATA_WIDTH  instruction word for fetch_address; meaningful only when cache_valid=1.
cache_valid  output  1  hit in IDLE; combinational from fetch_address.
cache_stall  output  1  fetch must hold its PC.
mem_req  output  1  refill beat request; held high for a whole refill.
mem_addr  output  DATA_WIDTH  word-aligned address of the current beat.
mem_ready  input  1  memory delivers mem_rdata this cycle.
mem_rdata  input  DATA_WIDTH  refill data beat.

Behaviour:
- Address split:
  - offset = addr[1:0] (ignored).
  - word = addr[log2(W)+1:2].
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage: data array LINES x W words, tag array, valid bit per line (flops).
- Reset:
  - all valid bits 0, state IDLE, mem_req=0, mem_addr=0.
  - cache_out=0 and cache_valid=0 while reset is high.
  - cache_stall=0.
- FSM states: IDLE, REFILL.
- IDLE:
  - hit = valid[index] && tag match.
  - cache_valid=hit; cache_out=data[index][word]; cache_stall=~hit.
  - On a miss, at the next edge: latch the line base address (word bits zeroed), beat counter=0, enter REFILL.
- REFILL:
  - mem_req=1; mem_addr = line base + 4*beat counter.
  - cache_valid=0; cache_stall=1.
  - Each cycle with mem_ready=1: write mem_rdata into data[index][beat] and increment the beat counter.
  - On beat W-1: write the tag, set the valid bit, return to IDLE.
  - mem_ready=0 inserts a wait cycle; nothing else changes.
- Latency:
  - hit: 0 cycles, combinational.
  - miss with mem_ready constantly 1: cache_valid rises W+1 cycles after the miss cycle (5 for W=4).
- fetch_address changes during REFILL (exception redirect): the refill completes for the latched line, then IDLE looks up the new address.
- invalidate:
  - In IDLE: all valid bits are cleared at the edge. That cycle's combinational hit result is still driven.
  - During REFILL: all valid bits are cleared, the refill completes, and the refilled line's valid bit is NOT set (a sticky flag is cleared on IDLE entry).
- Reset asserted mid-REFILL: mem_req drops the next cycle, state goes to IDLE, all lines become invalid. The partial line is never marked valid.
- The beat counter is log2(W) bits wide and is never compared beyond W-1.
- mem_addr increments wrap within DATA_WIDTH; no line crosses that boundary.

Optional Feature:
Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds output hit_count (32 bits) and output miss_count (32 bits), both reset to 0.
  - hit_count increments on each IDLE cycle with a hit.
  - miss_count increments once per IDLE-to-REFILL transition.
  - Both counters wrap modulo 2^32 and are not cleared by invalidate.
- Not defined: neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
1. Cold miss:
   - Stimulus: reset, then fetch_address=0x00000000; mem_ready=1; mem_rdata = 0xA0000000 + mem_addr.
   - Required: cache_stall=1 from the first cycle; mem_addr beats 0x0, 0x4, 0x8, 0xC; cache_valid=1 with cache_out=0xA0000000 exactly 5 cycles after the miss.
2. Hits in the filled line:
   - Stimulus: after test 1, fetch_address=0x4, 0x8, 0xC.
   - Required: cache_valid=1 in the same cycle; cache_out = 0xA0000004, 0xA0000008, 0xA000000C; mem_req stays 0.
3. Conflict eviction (LINES=16):
   - Stimulus: fetch 0x00000000, then 0x00000100, then 0x00000000.
   - Required: each access misses; the refill beats start at 0x100 and then at 0x0; the line holds the last-refilled tag.
4. Wait states:
   - Stimulus: miss at 0x20; mem_ready toggles 1,0,1,0,...
   - Required: only beats with mem_ready=1 are written; the refill takes 8 cycles; the final data is correct.
5. Invalidate during REFILL:
   - Stimulus: pulse invalidate on the second beat of the refill for 0x40.
   - Required: refill completes, but the following lookup of 0x40 misses and refills again.
6. Reset mid-refill:
   - Stimulus: assert reset after 2 beats.
   - Required: mem_req=0 next cycle; after reset, fetch 0x0 misses; hit_count=0 and miss_count=0 when ICACHE_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, whole-line refill over a req/ready bus.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module instruction_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fetch_address,
    input  logic                  invalidate,
    output logic [DATA_WIDTH-1:0] cache_out,
    output logic                  cache_valid,
    output logic                  cache_stall,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_LSB    = INDEX_BITS + WORD_BITS + 2;
    localparam int TAG_BITS   = DATA_WIDTH - TAG_LSB;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_reg;
    logic [WORD_BITS-1:0]    beat_reg;
    logic [INDEX_BITS-1:0]   refill_index_reg;
    logic [TAG_BITS-1:0]     refill_tag_reg;
    logic                    inval_seen_reg;

    logic [DATA_WIDTH-1:0]   data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic                    valid_reg [LINES];

    logic [WORD_BITS-1:0]    fetch_word;
    logic [INDEX_BITS-1:0]   fetch_index;
    logic [TAG_BITS-1:0]     fetch_tag;
    logic                    lookup_hit;
    logic                    idle_hit;
    logic                    beat_write;
    logic                    fill_done;
    logic                    unused_offset;

    assign fetch_word    = fetch_address[WORD_BITS+1:2];
    assign fetch_index   = fetch_address[TAG_LSB-1:WORD_BITS+2];
    assign fetch_tag     = fetch_address[DATA_WIDTH-1:TAG_LSB];
    assign unused_offset = ^fetch_address[1:0];

    assign lookup_hit = valid_reg[fetch_index] && (tag_mem[fetch_index] == fetch_tag);
    assign idle_hit   = (state_reg == IDLE) && lookup_hit;

    assign cache_valid = !reset && idle_hit;
    assign cache_stall = !reset && !idle_hit;
    assign cache_out   = reset ? '0 : data_mem[{fetch_index, fetch_word}];

    assign beat_write = !reset && (state_reg == REFILL) && mem_ready;
    assign fill_done  = beat_write && (beat_reg == WORD_BITS'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (beat_write) begin
            data_mem[{refill_index_reg, beat_reg}] <= mem_rdata;
        end
        if (fill_done) begin
            tag_mem[refill_index_reg] <= refill_tag_reg;
        end
    end

    // A line refilled while an invalidate was seen must stay invalid: its contents may be stale.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_reg[gi] <= 1'b0;
            end else if (fill_done && (refill_index_reg == INDEX_BITS'(gi))
                         && !(inval_seen_reg || invalidate)) begin
                valid_reg[gi] <= 1'b1;
            end else if (invalidate) begin
                valid_reg[gi] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            beat_reg         <= '0;
            refill_index_reg <= '0;
            refill_tag_reg   <= '0;
            inval_seen_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!lookup_hit) begin
                        state_reg        <= REFILL;
                        mem_req          <= 1'b1;
                        mem_addr         <= {fetch_address[DATA_WIDTH-1:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
                        beat_reg         <= '0;
                        refill_index_reg <= fetch_index;
                        refill_tag_reg   <= fetch_tag;
                        inval_seen_reg   <= 1'b0;
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        inval_seen_reg <= 1'b1;
                    end
                    if (mem_ready) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (beat_reg == WORD_BITS'(WORDS_PER_LINE - 1)) begin
                            state_reg      <= IDLE;
                            mem_req        <= 1'b0;
                            inval_seen_reg <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + DATA_WIDTH'(4);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_reg == IDLE) begin
            if (lookup_hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: refill beats are scoreboarded through a queue of expected addresses.
`timescale 1ns/1ps
module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_address;
    logic        invalidate;
    logic [31:0] cache_out;
    logic        cache_valid;
    logic        cache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    // Memory returns a recognisable pattern derived from the beat address.
    assign mem_rdata = 32'hA000_0000 + mem_addr;

    instruction_cache dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_address(fetch_address),
        .invalidate   (invalidate),
        .cache_out    (cache_out),
        .cache_valid  (cache_valid),
        .cache_stall  (cache_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the miss cycle with fetch_address already applied; follows the refill until mem_req drops.
    task automatic do_miss(input logic [31:0] addr, input bit alt_ready, input int inval_cycle,
                           input bit exp_fill_valid, input int exp_latency);
        logic [31:0] base;
        logic [31:0] exp_addr;
        int          cyc;
        base = addr & 32'hFFFF_FFF0;
        check("miss_stall", {31'd0, cache_stall}, 32'd1);
        check("miss_valid", {31'd0, cache_valid}, 32'd0);
        for (int b = 0; b < 4; b++) exp_q.push_back(base + 32'(b * 4));
        cyc = 0;
        do begin
            step();
            cyc++;
            mem_ready  = alt_ready ? (cyc % 2 == 0) : 1'b1;
            invalidate = (cyc == inval_cycle);
            #1;
            if (mem_req) begin
                check("refill_stall", {31'd0, cache_stall}, 32'd1);
                if (mem_ready) begin
                    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                    check("beat_addr", mem_addr, exp_addr);
                end
            end
        end while (mem_req && cyc < 40);
        invalidate = 1'b0;
        mem_ready  = 1'b1;
        check("refill_latency", cyc, exp_latency);
        check("beats_left", exp_q.size(), 0);
        exp_q.delete();
        check("fill_valid", {31'd0, cache_valid}, {31'd0, exp_fill_valid});
        if (exp_fill_valid) check("fill_data", cache_out, 32'hA000_0000 + (addr & 32'hFFFF_FFFC));
        $display("[TB] refill 0x%08h done after %0d cycles", addr, cyc);
    endtask

    task automatic expect_hit(input logic [31:0] addr);
        fetch_address = addr;
        #1;
        check("hit_valid", {31'd0, cache_valid}, 32'd1);
        check("hit_data", cache_out, 32'hA000_0000 + addr);
        check("hit_no_req", {31'd0, mem_req}, 32'd0);
        $display("[TB] hit 0x%08h -> 0x%08h", addr, cache_out);
        step();
    endtask

    initial begin
        reset         = 1'b1;
        fetch_address = '0;
        invalidate    = 1'b0;
        mem_ready     = 1'b0;
        step();
        step();
        #1;
        check("rst_valid", {31'd0, cache_valid}, 32'd0);
        check("rst_out", cache_out, 32'd0);
        check("rst_stall", {31'd0, cache_stall}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        reset = 1'b0;

        // Cold miss, then hits in the same line.
        fetch_address = 32'h0;
        mem_ready     = 1'b1;
        #1;
        do_miss(32'h0, 1'b0, -1, 1'b1, 5);
        step();
        expect_hit(32'h4);
        expect_hit(32'h8);
        expect_hit(32'hC);
`ifdef ICACHE_PERF_CNT_EN
        check("miss_count_1", miss_count, 32'd1);
`endif

        // Conflict eviction on index 0.
        fetch_address = 32'h100;
        #1;
        do_miss(32'h100, 1'b0, -1, 1'b1, 5);
        fetch_address = 32'h0;
        #1;
        do_miss(32'h0, 1'b0, -1, 1'b1, 5);
        fetch_address = 32'h104;
        #1;
        do_miss(32'h104, 1'b0, -1, 1'b1, 5);
        step();
        expect_hit(32'h108);

        // Wait states: ready alternates starting high in the miss cycle.
        fetch_address = 32'h20;
        #1;
        do_miss(32'h20, 1'b1, -1, 1'b1, 9);
        step();
        expect_hit(32'h24);
        expect_hit(32'h28);
        expect_hit(32'h2C);

        // Invalidate on the second beat: refill completes but the line stays invalid.
        fetch_address = 32'h40;
        #1;
        do_miss(32'h40, 1'b0, 2, 1'b0, 5);
        do_miss(32'h40, 1'b0, -1, 1'b1, 5);

        // Invalidate in IDLE: this cycle still hits, the next one misses.
        invalidate = 1'b1;
        #1;
        check("inval_same_cycle_hit", {31'd0, cache_valid}, 32'd1);
        step();
        invalidate = 1'b0;
        #1;
        do_miss(32'h40, 1'b0, -1, 1'b1, 5);

        // Reset after two beats of a refill.
        fetch_address = 32'h80;
        #1;
        check("rstmid_stall", {31'd0, cache_stall}, 32'd1);
        step();
        step();
        step();
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rstmid_req_before", {31'd0, mem_req}, 32'd1);
        step();
        #1;
        check("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
        check("rstmid_valid", {31'd0, cache_valid}, 32'd0);
        check("rstmid_stall_low", {31'd0, cache_stall}, 32'd0);
        reset         = 1'b0;
        mem_ready     = 1'b1;
        fetch_address = 32'h0;
        #1;
`ifdef ICACHE_PERF_CNT_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        do_miss(32'h0, 1'b0, -1, 1'b1, 5);
        fetch_address = 32'h84;
        #1;
        do_miss(32'h84, 1'b0, -1, 1'b1, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
